grid_sweep_scheduler: RTL and testbench

//  Sequences the per-tick raster sweep of the environment grid: steps write location
//  (loc_x,loc_y) over every cell once per game tick, holds each cell for the env-cache

---
 rtl/grid_sweep_scheduler.sv | 131 +++++++++++++
 tb/tb_grid_sweep_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/grid_sweep_scheduler.sv
// rtl/grid_sweep_scheduler.sv - raster sweep sequencer driving loc_x/loc_y and the per-cell write strobe
module grid_sweep_scheduler #(
  parameter int X_BITS   = 8,
  parameter int Y_BITS   = 7,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int READ_LAT = 2,
  parameter int OVR_BITS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                run,
  input  logic                pause_n,
  input  logic                game_tick,
  output logic [X_BITS-1:0]   loc_x,
  output logic [Y_BITS-1:0]   loc_y,
  output logic                hold_locs,
  output logic                write_flag,
  output logic                busy,
  output logic                sweep_done,
  output logic [OVR_BITS-1:0] overrun_cnt
);

  localparam int W_BITS = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, ADVANCE, PAUSE, DONE} state_t;

  state_t              state_q, state_d;
  logic [X_BITS-1:0]   loc_x_q, loc_x_d;
  logic [Y_BITS-1:0]   loc_y_q, loc_y_d;
  logic [W_BITS-1:0]   wait_q, wait_d;
  logic [OVR_BITS-1:0] ovr_q;
  logic                sync1_q, sync2_q;
  logic                hold_q, wflag_q, busy_q, done_q;
  logic                paused, last_x, last_cell;

  assign paused    = ~sync2_q;
  assign last_x    = (loc_x_q == X_BITS'(X_MAX));
  assign last_cell = last_x && (loc_y_q == Y_BITS'(Y_MAX));

  always_comb begin
    state_d = state_q;
    loc_x_d = loc_x_q;
    loc_y_d = loc_y_q;
    wait_d  = wait_q;
    if (state_q != IDLE && !run) begin
      // Abort: back to the origin without a completion pulse.
      state_d = IDLE;
      loc_x_d = '0;
      loc_y_d = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (game_tick && run && !paused) begin
          state_d = FETCH;
          loc_x_d = '0;
          loc_y_d = '0;
          wait_d  = '0;
        end
        FETCH: begin
          if (wait_q == W_BITS'(READ_LAT - 1)) state_d = WRITE;
          else wait_d = wait_q + W_BITS'(1);
        end
        WRITE: state_d = ADVANCE;
        ADVANCE: begin
          if (last_cell) begin
            state_d = DONE;
          end else begin
            if (last_x) begin
              loc_x_d = '0;
              loc_y_d = loc_y_q + Y_BITS'(1);
            end else begin
              loc_x_d = loc_x_q + X_BITS'(1);
            end
            wait_d  = '0;
            state_d = paused ? PAUSE : FETCH;
          end
        end
        PAUSE: if (!paused) begin
          state_d = FETCH;
          wait_d  = '0;
        end
        DONE: begin
          state_d = IDLE;
          loc_x_d = '0;
          loc_y_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      loc_x_q <= '0;
      loc_y_q <= '0;
      wait_q  <= '0;
      ovr_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hold_q  <= 1'b1;
      wflag_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= pause_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      loc_x_q <= loc_x_d;
      loc_y_q <= loc_y_d;
      wait_q  <= wait_d;
      // Outputs are registered from the next state so they line up with it.
      hold_q  <= (state_d != ADVANCE);
      wflag_q <= (state_d == WRITE);
      busy_q  <= (state_d == FETCH) || (state_d == WRITE) ||
                 (state_d == ADVANCE) || (state_d == PAUSE);
      done_q  <= (state_q == DONE) && run;
      if (game_tick && state_q != IDLE && ovr_q != '1) ovr_q <= ovr_q + OVR_BITS'(1);
    end
  end

  assign loc_x       = loc_x_q;
  assign loc_y       = loc_y_q;
  assign hold_locs   = hold_q;
  assign write_flag  = wflag_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_grid_sweep_scheduler.sv
// tb/tb_grid_sweep_scheduler.sv - directed self-checking bench with a write_flag cell scoreboard
module tb_grid_sweep_scheduler;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       run = 1'b1;
  logic       pause_n = 1'b1;
  logic       game_tick = 1'b0;
  logic [7:0] loc_x;
  logic [6:0] loc_y;
  logic       hold_locs, write_flag, busy, sweep_done;
  logic [7:0] overrun_cnt;

  int ncmp = 0;
  int nfail = 0;
  logic [14:0] exp_q[$];

  grid_sweep_scheduler #(
    .X_BITS(8), .Y_BITS(7), .X_MAX(3), .Y_MAX(1), .READ_LAT(2), .OVR_BITS(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .run(run), .pause_n(pause_n), .game_tick(game_tick),
    .loc_x(loc_x), .loc_y(loc_y), .hold_locs(hold_locs), .write_flag(write_flag),
    .busy(busy), .sweep_done(sweep_done), .overrun_cnt(overrun_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_cells(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i % 4), 7'(i / 4)});
  endtask

  task automatic tick();
    @(negedge Clk) game_tick = 1'b1;
    @(negedge Clk) game_tick = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (sweep_done !== 1'b1 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk(tag, sweep_done, 1);
  endtask

  // Scoreboard: every write_flag must match the next expected cell.
  always @(negedge Clk) begin
    if (!Reset && write_flag === 1'b1) begin
      ncmp++;
      assert (exp_q.size() != 0) else begin
        nfail++;
        $error("FAIL extra_write observed=(%0d,%0d) expected=none", loc_x, loc_y);
      end
      if (exp_q.size() != 0) begin
        logic [14:0] e;
        e = exp_q.pop_front();
        chk("cell", {17'd0, loc_x, loc_y}, {17'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_loc_x", loc_x, 0);
    chk("rst_loc_y", loc_y, 0);
    chk("rst_hold", hold_locs, 1);
    chk("rst_wflag", write_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_ovr", overrun_cnt, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Full sweep, cycle-exact write_flag and sweep_done timing.
    push_cells(8);
    tick();
    chk("t1_busy", busy, 1);
    for (int c = 0; c < 33; c++) begin
      chk($sformatf("t1_wf_c%0d", c), write_flag, (c % 4 == 2) ? 1 : 0);
      chk($sformatf("t1_sd_c%0d", c), sweep_done, 0);
      @(negedge Clk);
    end
    chk("t1_done", sweep_done, 1);
    chk("t1_loc_x", loc_x, 0);
    chk("t1_loc_y", loc_y, 0);
    chk("t1_hold", hold_locs, 1);
    chk("t1_busy_end", busy, 0);
    @(negedge Clk);
    chk("t1_done_pulse", sweep_done, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // Overrun tick mid-sweep.
    repeat (3) @(negedge Clk);
    push_cells(8);
    tick();
    repeat (10) @(negedge Clk);
    tick();
    wait_done("t2_done");
    chk("t2_ovr", overrun_cnt, 1);
    chk("t2_q_empty", exp_q.size(), 0);

    // Pause during cell (1,0) fetch.
    repeat (3) @(negedge Clk);
    push_cells(8);
    tick();
    repeat (4) @(negedge Clk);
    pause_n = 1'b0;
    repeat (11) @(negedge Clk);
    chk("t3_loc_x", loc_x, 2);
    chk("t3_loc_y", loc_y, 0);
    chk("t3_busy", busy, 1);
    chk("t3_wflag", write_flag, 0);
    chk("t3_q_left", exp_q.size(), 6);
    pause_n = 1'b1;
    wait_done("t3_done");
    chk("t3_q_empty", exp_q.size(), 0);

    // Run drops during cell (2,1).
    repeat (3) @(negedge Clk);
    push_cells(6);
    tick();
    repeat (24) @(negedge Clk);
    run = 1'b0;
    @(negedge Clk);
    chk("t4_busy", busy, 0);
    chk("t4_loc_x", loc_x, 0);
    chk("t4_loc_y", loc_y, 0);
    chk("t4_wflag", write_flag, 0);
    for (int c = 0; c < 10; c++) begin
      chk("t4_no_done", sweep_done, 0);
      @(negedge Clk);
    end
    chk("t4_q_empty", exp_q.size(), 0);
    run = 1'b1;
    push_cells(8);
    tick();
    wait_done("t4_restart_done");
    chk("t4_restart_q", exp_q.size(), 0);
    chk("t4_ovr_kept", overrun_cnt, 1);

    // Asynchronous reset in the middle of a WRITE cycle.
    repeat (3) @(negedge Clk);
    push_cells(1);
    tick();
    repeat (2) @(negedge Clk);
    chk("t5_wf_before", write_flag, 1);
    #2 Reset = 1'b1;
    #1;
    chk("t5_wflag", write_flag, 0);
    chk("t5_busy", busy, 0);
    chk("t5_hold", hold_locs, 1);
    chk("t5_loc_x", loc_x, 0);
    chk("t5_loc_y", loc_y, 0);
    chk("t5_ovr", overrun_cnt, 0);
    chk("t5_done", sweep_done, 0);
    @(negedge Clk) Reset = 1'b0;
    chk("t5_q_empty", exp_q.size(), 0);

    // Saturation: stall a sweep in PAUSE, then flood ticks.
    repeat (2) @(negedge Clk);
    push_cells(1);
    tick();
    pause_n = 1'b0;
    repeat (10) @(negedge Clk);
    chk("t6_paused_busy", busy, 1);
    chk("t6_loc_x", loc_x, 1);
    game_tick = 1'b1;
    repeat (300) @(negedge Clk);
    game_tick = 1'b0;
    chk("t6_ovr_sat", overrun_cnt, 255);
    run = 1'b0;
    @(negedge Clk);
    chk("t6_abort_busy", busy, 0);
    chk("t6_ovr_kept", overrun_cnt, 255);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
